// File: rtl/core_pkg.sv
// Shared core types: fetch-entry layout and the canonical NOP word.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear and an occupancy count output.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & (count != FULL) & ~clear;
  assign do_pop  = pop & (count != '0) & ~clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; consumers only look at it when count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: credit-limited in-order memory reads feeding a
// decode FIFO, with redirect flush and misaligned-PC fault entries.
module if_fetch_unit
  import core_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_valid_i,
  output logic            stall_o,
  input  logic            flush_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_fault_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   pend_count;
  logic [XLEN-1:0] pend_pc;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;
  logic            aligned;
  logic            credit;
  logic            req_fire;
  logic            rsp_write;
  logic            fault_write;
  logic            inst_pop;

  // A fault entry yields the FIFO write port to a returning response.
  always_comb begin
    aligned          = pc_i[1:0] == 2'b00;
    credit           = ({1'b0, outstanding} + {1'b0, fifo_count}) < LIMIT;
    imem_req_valid_o = pc_valid_i & credit & ~flush_i & aligned;
    req_fire         = imem_req_valid_o & imem_req_ready_i;
    rsp_write        = imem_rsp_valid_i & ~flush_i & (drop == '0);
    fault_write      = pc_valid_i & credit & ~flush_i & ~aligned & ~rsp_write;
    stall_o          = pc_valid_i & ~flush_i & ~(req_fire | fault_write);
    if (rsp_write) begin
      wr_entry = '{inst: imem_rsp_data_i, pc: pend_pc, fault: 1'b0};
    end else begin
      wr_entry = '{inst: NOP, pc: pc_i, fault: 1'b1};
    end
  end

  assign imem_req_addr_o = pc_i;
  assign inst_valid_o    = fifo_count != '0;
  assign inst_pop        = inst_valid_o & inst_ready_i;
  assign inst_o          = inst_valid_o ? head.inst : '0;
  assign inst_pc_o       = inst_valid_o ? head.pc : '0;
  assign inst_fault_o    = inst_valid_o & head.fault;

  // On a redirect every still-in-flight request becomes a response to discard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid_i);
      if (flush_i) begin
        drop <= outstanding - CW'(imem_rsp_valid_i);
      end else if (imem_rsp_valid_i && drop != '0) begin
        drop <= drop - CW'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush_i),
    .push    (rsp_write | fault_write),
    .wdata   (wr_entry),
    .pop     (inst_pop),
    .rdata   (head),
    .count   (fifo_count)
  );

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pend_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush_i),
    .push    (req_fire),
    .wdata   (pc_i),
    .pop     (rsp_write),
    .rdata   (pend_pc),
    .count   (pend_count)
  );

  rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rsp_valid_i |-> outstanding != '0);

  pend_tracks_live_requests: assert property (@(posedge clk) disable iff (!reset_n)
    pend_count == outstanding - drop);

  reset_pc_word_aligned: assert property (@(posedge clk) RESET_PC[1:0] == 2'b00);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory model, queue-based reference
// model compared every cycle, plus directed literal expectations.
module tb_if_fetch_unit;
  import core_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        imem_req_ready_i = 1'b0;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        inst_ready_i = 1'b0;
  logic        stall_o;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_fault_o;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int lat = 1;

  if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pc_i             (pc_i),
    .pc_valid_i       (pc_valid_i),
    .stall_o          (stall_o),
    .flush_i          (flush_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_fault_o     (inst_fault_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic fl,
                               input logic rdy, input logic ir);
    @(negedge clk);
    pc_valid_i       = pv;
    pc_i             = pc;
    flush_i          = fl;
    imem_req_ready_i = rdy;
    inst_ready_i     = ir;
  endtask

  // Instruction memory: fixed latency, in-order responses.
  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t mem_q[$];

  always @(negedge clk) begin
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
    #1;
    if (!reset_n) begin
      mem_q.delete();
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end else if (imem_req_valid_o && imem_req_ready_i) begin
      mem_q.push_back('{due: cyc + lat, data: memWord(imem_req_addr_o)});
    end
  end

  // Reference model: decode queue, live pending PCs, in-flight and discard counts.
  typedef struct { logic [31:0] inst; logic [31:0] pc; logic fault; } ent_t;
  ent_t        mq[$];
  logic [31:0] mpend[$];
  int          mout = 0;
  int          mdrop = 0;

  always @(negedge clk) begin : compare_proc
    bit          credit, aligned, eReq, fire, rspW, fltW, eStall, eValid;
    logic [31:0] p;
    #2;
    if (!reset_n) begin
      mq.delete();
      mpend.delete();
      mout  = 0;
      mdrop = 0;
      checkOutput("rst_stall", stall_o, 0);
      checkOutput("rst_req_valid", imem_req_valid_o, 0);
      checkOutput("rst_req_addr", imem_req_addr_o, 0);
      checkOutput("rst_inst_valid", inst_valid_o, 0);
      checkOutput("rst_inst", inst_o, 0);
      checkOutput("rst_inst_pc", inst_pc_o, 0);
      checkOutput("rst_fault", inst_fault_o, 0);
    end else begin
      credit  = (mout + mq.size()) < DEPTH;
      aligned = pc_i[1:0] == 2'b00;
      eReq    = pc_valid_i && credit && !flush_i && aligned;
      fire    = eReq && imem_req_ready_i;
      rspW    = imem_rsp_valid_i && !flush_i && mdrop == 0;
      fltW    = pc_valid_i && credit && !flush_i && !aligned && !rspW;
      eStall  = pc_valid_i && !flush_i && !(fire || fltW);
      eValid  = mq.size() > 0;
      checkOutput("stall_o", stall_o, eStall);
      checkOutput("imem_req_valid_o", imem_req_valid_o, eReq);
      if (eReq) checkOutput("imem_req_addr_o", imem_req_addr_o, pc_i);
      checkOutput("inst_valid_o", inst_valid_o, eValid);
      checkOutput("inst_o", inst_o, eValid ? mq[0].inst : 32'h0);
      checkOutput("inst_pc_o", inst_pc_o, eValid ? mq[0].pc : 32'h0);
      checkOutput("inst_fault_o", inst_fault_o, eValid ? mq[0].fault : 1'b0);
      if (flush_i) begin
        mq.delete();
        mpend.delete();
        if (imem_rsp_valid_i) mout--;
        mdrop = mout;
      end else begin
        if (eValid && inst_ready_i) void'(mq.pop_front());
        if (imem_rsp_valid_i) begin
          mout--;
          if (mdrop > 0) begin
            mdrop--;
          end else begin
            p = mpend.pop_front();
            mq.push_back('{imem_rsp_data_i, p, 1'b0});
          end
        end
        if (fltW) mq.push_back('{NOP, pc_i, 1'b1});
        if (fire) begin
          mout++;
          mpend.push_back(pc_i);
        end
      end
    end
  end

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    #3;
    checkOutput("reset_inst_valid", inst_valid_o, 0);
    checkOutput("reset_stall", stall_o, 0);
    reset_n = 1'b1;

    // Back-to-back fetch, L=1, decode always ready.
    applyStimulus(1, 32'h0, 0, 1, 1); #3;
    checkOutput("t1_stall_c0", stall_o, 0);
    checkOutput("t1_req_c0", imem_req_valid_o, 1);
    applyStimulus(1, 32'h4, 0, 1, 1); #3;
    checkOutput("t1_stall_c1", stall_o, 0);
    applyStimulus(1, 32'h8, 0, 1, 1); #3;
    checkOutput("t1_valid_c2", inst_valid_o, 1);
    checkOutput("t1_pc_c2", inst_pc_o, 32'h0);
    checkOutput("t1_inst_c2", inst_o, 32'hC0DE_0000);
    checkOutput("t1_stall_c2", stall_o, 0);
    applyStimulus(0, 32'h0, 0, 1, 1); #3;
    checkOutput("t1_pc_c3", inst_pc_o, 32'h4);
    applyStimulus(0, 32'h0, 0, 1, 1); #3;
    checkOutput("t1_pc_c4", inst_pc_o, 32'h8);
    applyStimulus(0, 32'h0, 0, 1, 1); #3;
    checkOutput("t1_empty_c5", inst_valid_o, 0);

    // Decode blocked: credit limit stalls the fifth PC.
    applyStimulus(1, 32'h0, 0, 1, 0);
    applyStimulus(1, 32'h4, 0, 1, 0);
    applyStimulus(1, 32'h8, 0, 1, 0); #3;
    checkOutput("t2_pc_c2", inst_pc_o, 32'h0);
    applyStimulus(1, 32'hC, 0, 1, 0); #3;
    checkOutput("t2_stall_c3", stall_o, 0);
    applyStimulus(1, 32'h10, 0, 1, 0); #3;
    checkOutput("t2_stall_c4", stall_o, 1);
    applyStimulus(1, 32'h10, 0, 1, 0); #3;
    checkOutput("t2_stall_c5", stall_o, 1);
    checkOutput("t2_pc_c5", inst_pc_o, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 32'h0, 0, 1, 1); #3;
      checkOutput("t2_drain_pc", inst_pc_o, 32'(4 * i));
    end
    applyStimulus(0, 32'h0, 0, 1, 1); #3;
    checkOutput("t2_drained", inst_valid_o, 0);

    // Flush with two requests in flight, none returning on the flush cycle.
    lat = 3;
    applyStimulus(1, 32'h10, 0, 1, 1);
    applyStimulus(1, 32'h14, 0, 1, 1);
    applyStimulus(1, 32'h200, 1, 1, 1); #3;
    checkOutput("t3_flush_stall", stall_o, 0);
    checkOutput("t3_flush_req", imem_req_valid_o, 0);
    applyStimulus(1, 32'h100, 0, 1, 1); #3;
    checkOutput("t3_target_req", imem_req_valid_o, 1);
    found = 0;
    for (int k = 1; k <= 12 && !found; k++) begin
      applyStimulus(0, 32'h0, 0, 1, 1); #3;
      if (inst_valid_o) begin
        found = 1;
        checkOutput("t3_first_pc", inst_pc_o, 32'h100);
        checkOutput("t3_first_inst", inst_o, 32'hC0DE_0100);
        checkOutput("t3_latency", k, 4);
      end
    end
    checkOutput("t3_seen", found, 1);

    // Flush on the cycle a response returns, one more still in flight.
    applyStimulus(0, 32'h0, 0, 1, 1);
    applyStimulus(0, 32'h0, 0, 1, 1);
    lat = 2;
    applyStimulus(1, 32'h40, 0, 1, 1);
    applyStimulus(1, 32'h44, 0, 1, 1);
    applyStimulus(1, 32'h300, 1, 1, 1);
    applyStimulus(1, 32'h48, 0, 1, 1);
    found = 0;
    for (int k = 1; k <= 12 && !found; k++) begin
      applyStimulus(0, 32'h0, 0, 1, 1); #3;
      if (inst_valid_o) begin
        found = 1;
        checkOutput("t4_first_pc", inst_pc_o, 32'h48);
        checkOutput("t4_latency", k, 3);
      end
    end
    checkOutput("t4_seen", found, 1);
    applyStimulus(0, 32'h0, 0, 1, 1); #3;
    checkOutput("t4_no_extra", inst_valid_o, 0);

    // Misaligned PC becomes a NOP fault entry without a memory request.
    lat = 1;
    applyStimulus(1, 32'h22, 0, 1, 0); #3;
    checkOutput("t5_no_req", imem_req_valid_o, 0);
    checkOutput("t5_stall", stall_o, 0);
    applyStimulus(0, 32'h0, 0, 1, 0); #3;
    checkOutput("t5_valid", inst_valid_o, 1);
    checkOutput("t5_fault", inst_fault_o, 1);
    checkOutput("t5_nop", inst_o, 32'h0000_0013);
    checkOutput("t5_pc", inst_pc_o, 32'h22);
    applyStimulus(0, 32'h0, 0, 1, 1);
    applyStimulus(0, 32'h0, 0, 1, 1); #3;
    checkOutput("t5_popped", inst_valid_o, 0);

    // Fault entry collides with a returning response and waits a cycle.
    applyStimulus(1, 32'h30, 0, 1, 1);
    applyStimulus(1, 32'h32, 0, 1, 1); #3;
    checkOutput("t5b_stall", stall_o, 1);
    applyStimulus(1, 32'h32, 0, 1, 1); #3;
    checkOutput("t5b_stall_next", stall_o, 0);
    checkOutput("t5b_pc_first", inst_pc_o, 32'h30);
    applyStimulus(0, 32'h0, 0, 1, 1); #3;
    checkOutput("t5b_pc_fault", inst_pc_o, 32'h32);
    checkOutput("t5b_fault", inst_fault_o, 1);
    applyStimulus(0, 32'h0, 0, 1, 1);

    // Memory not ready for three cycles: same PC held, delivered once.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h80, 0, 0, 1); #3;
      checkOutput("t6_stall", stall_o, 1);
      checkOutput("t6_req_addr", imem_req_addr_o, 32'h80);
      checkOutput("t6_req_valid", imem_req_valid_o, 1);
    end
    applyStimulus(1, 32'h80, 0, 1, 1); #3;
    checkOutput("t6_accept_stall", stall_o, 0);
    applyStimulus(0, 32'h0, 0, 1, 1); #3;
    checkOutput("t6_not_yet", inst_valid_o, 0);
    applyStimulus(0, 32'h0, 0, 1, 1); #3;
    checkOutput("t6_pc", inst_pc_o, 32'h80);
    applyStimulus(0, 32'h0, 0, 1, 1); #3;
    checkOutput("t6_once", inst_valid_o, 0);

    // Reset in the middle of traffic clears everything.
    applyStimulus(1, 32'h500, 0, 1, 0);
    applyStimulus(1, 32'h504, 0, 1, 0);
    @(negedge clk);
    reset_n = 1'b0;
    pc_valid_i = 0; pc_i = '0; flush_i = 0; imem_req_ready_i = 0; inst_ready_i = 0;
    #3;
    checkOutput("t7_rst_valid", inst_valid_o, 0);
    @(negedge clk);
    #3;
    reset_n = 1'b1;
    applyStimulus(1, 32'h600, 0, 1, 1);
    applyStimulus(0, 32'h0, 0, 1, 1);
    applyStimulus(0, 32'h0, 0, 1, 1); #3;
    checkOutput("t7_after_valid", inst_valid_o, 1);
    checkOutput("t7_after_pc", inst_pc_o, 32'h600);
    applyStimulus(0, 32'h0, 0, 1, 1);
    applyStimulus(0, 32'h0, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch front end sitting between the PC counter and the decode stage of the RV32I core. Accepts the current PC each cycle, issues in-order word reads to instruction memory over a valid/ready request channel, and buffers returned instructions with their PC in a small FIFO for decode. Back-pressures the PC counter through its stall input and discards queued and in-flight fetches when a jump or branch redirect flushes the front end.

## Interface
- DEPTH, 4, instruction FIFO entries; also the credit limit on outstanding plus buffered fetches (power of two, ≥2)
- RESET_PC, 32'h0000_0000, informational only; the PC counter owns the reset PC
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pc_i  in  32  fetch address from PC counter
- pc_valid_i  in  1  pc_i is a fetch candidate this cycle
- stall_o  out  1  to PC counter stall input: hold PC, fetch not taken
- flush_i  in  1  redirect (jalr, jal or taken branch) this cycle
- imem_req_valid_o  out  1  read request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  32  word address, equals pc_i
- imem_rsp_valid_i  in  1  read data returned, in request order, ≥1 cycle after acceptance
- imem_rsp_data_i  in  32  instruction word
- inst_valid_o  out  1  FIFO head valid
- inst_ready_i  in  1  decode takes FIFO head
- inst_o  out  32  instruction at head
- inst_pc_o  out  32  PC of instruction at head
- inst_fault_o  out  1  head entry is a misaligned fetch (pc[1:0]≠0); inst_o is 32'h0000_0013 (NOP)

## Operation
- Counters: outstanding (requests accepted, response not yet arrived), count (FIFO occupancy), drop (responses still to be discarded). All 0 after reset.
- Credit: request allowed when outstanding + count < DEPTH.
- Issue: imem_req_valid_o = pc_valid_i & credit & !flush_i & pc_i[1:0]==0. Accepted when also imem_req_ready_i; pc_i pushed into pending-PC queue (DEPTH entries).
- Misaligned pc_i with credit and !flush_i: no memory request; fault entry written directly to FIFO (when no response write occurs that cycle; otherwise stalls one cycle).
- stall_o = pc_valid_i & !(request accepted | fault entry written).
- Response: if drop>0, discard and decrement drop; else pop pending PC, write {data, pc, fault=0} to FIFO. outstanding decrements either way.
- Pop: inst_valid_o & inst_ready_i removes head.
- Flush: FIFO and pending queue cleared; drop ← outstanding minus 1 if a response arrives that same cycle (that response is discarded); outstanding tracks real in-flight requests. No request issued on flush cycle; stall_o low on flush cycle (PC counter is loading the target).
- Simultaneous push and pop on full FIFO permitted only if count<DEPTH before push; credit rule guarantees no overflow.
- Response with outstanding==0 is a protocol violation; assertion only.

## Timing
- Reset: all outputs 0 (stall_o, imem_req_valid_o, inst_valid_o, inst_fault_o low; buses 0), counters and pointers 0.
- No combinational path imem_rsp → inst outputs; written entry visible next cycle.
- Fetch latency: memory latency L plus 1 cycle from request acceptance to inst_valid_o.
- Throughput: one instruction per cycle sustained with L=1 and DEPTH=4.
- imem_req_valid_o may drop without acceptance (PC redirect); memory must not rely on request stability.
- Reset asserted mid-operation: immediate clear of all state; in-flight responses after reset release are not tracked (memory reset together with core).

## Structure
- Shared package core_pkg: fetch-entry struct {inst, pc, fault}, NOP constant 32'h0000_0013, XLEN.
- One sub-module: sync_fifo (parameterised width/depth, count output), instantiated twice: instruction FIFO and pending-PC queue.

## Test plan
- Reset then pc_i=0,4,8 valid, L=1, ready always → inst_pc_o 0,4,8 on consecutive cycles from cycle 2, stall_o never high.
- inst_ready_i low, 6 PCs offered → 4 requests accepted, stall_o high from 5th, inst_valid_o held on pc 0.
- Two requests outstanding (pc 0x10, 0x14), flush_i with pc 0x100 next → both responses dropped, first delivered inst_pc_o=0x100.
- Flush in same cycle a response arrives, one other outstanding → both discarded, drop returns to 0.
- pc_i=0x22 → no memory request, inst_fault_o=1, inst_o=0x00000013, inst_pc_o=0x22.
- imem_req_ready_i low 3 cycles → stall_o high 3 cycles, same PC requested, delivered once.
